serv_comppack: RTL and testbench

- Instruction-stream compressor and packer: the write-side counterpart of the RV32C expander in the fetch path.
- Accepts RV32I instruction words, re-encodes each qualifying instruction to its 16-bit RVC form, and packs the 16/32-bit parcels into little-endian 32-bit memory words.
- Used by the boot-image loader and self-test generator to build compressed program memory for SERV.
- Input and output are valid/ready streams; a one-halfword residual buffer tracks alignment.

---
 rtl/serv_comppack_if.sv | 63 ++++++
 rtl/serv_comppack.sv | 267 ++++++++++++++++++++++++++
 tb/tb_serv_comppack.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_comppack_if.sv
// -----------------------------------------------------------------------------
// serv_comppack_if
//
// Stream bundle for the instruction compressor/packer.
//
// Handshake semantics (both directions): a beat transfers on a rising clock
// edge where the producer's valid and the consumer's ready are both high.
// A producer holding valid high keeps its payload stable until the transfer.
// The input side carries either an instruction (i_valid) or, when no
// instruction is offered, a flush request (i_flush). Both share o_ready.
//
// Signals
//   i_instr   [31:0]  RV32I instruction word                (master -> slave)
//   i_valid           i_instr valid                         (master -> slave)
//   i_flush           pad residual halfword to a word edge  (master -> slave)
//   o_ready           slave can accept a beat               (slave  -> master)
//   o_word    [31:0]  packed word, [15:0] = lower address   (slave  -> master)
//   o_valid           o_word valid                          (slave  -> master)
//   i_ready           master accepts o_word                 (master -> slave)
//   o_comp            last accepted instruction compressed  (slave  -> master)
//   o_ncomp   [15:0]  saturating compressed-instr count     (slave  -> master)
//   dbg_state         packing state: 0 = EMPTY, 1 = HALF    (slave  -> master)
// -----------------------------------------------------------------------------
interface serv_comppack_if;
    logic [31:0] i_instr;
    logic        i_valid;
    logic        i_flush;
    logic        o_ready;
    logic [31:0] o_word;
    logic        o_valid;
    logic        i_ready;
    logic        o_comp;
    logic [15:0] o_ncomp;
    logic        dbg_state;

    // Design side
    modport slave (
        input  i_instr,
        input  i_valid,
        input  i_flush,
        output o_ready,
        output o_word,
        output o_valid,
        input  i_ready,
        output o_comp,
        output o_ncomp,
        output dbg_state
    );

    // Driver / sink side
    modport master (
        output i_instr,
        output i_valid,
        output i_flush,
        input  o_ready,
        input  o_word,
        input  o_valid,
        output i_ready,
        input  o_comp,
        input  o_ncomp,
        input  dbg_state
    );
endinterface

// File: rtl/serv_comppack.sv
// -----------------------------------------------------------------------------
// serv_comppack
//
// Write-side counterpart of the RV32C expander: takes RV32I instruction words,
// re-encodes each qualifying one into its 16-bit RVC form and packs the
// resulting 16/32-bit parcels into little-endian 32-bit memory words.
// A single pending lower halfword (the residual) tracks halfword alignment.
//
// Parameters
//   COMPRESS  1 = compress qualifying instructions, 0 = emit everything as 32-bit
//   PAD       halfword placed in a dangling upper half on flush (c.nop)
//
// Ports
//   i_clk     clock
//   i_rst_n   synchronous reset, active low
//   bus       serv_comppack_if.slave: input instruction/flush stream,
//             output word stream, o_comp / o_ncomp status, dbg_state
//
// Handshake: input beat accepted when (i_valid | i_flush) & o_ready, with
// o_ready = !o_valid | i_ready. Output register is a single entry; o_word
// appears the cycle after acceptance and holds while o_valid & !i_ready.
// -----------------------------------------------------------------------------
module serv_comppack #(
    parameter bit          COMPRESS = 1'b1,
    parameter logic [15:0] PAD      = 16'h0001
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    serv_comppack_if.slave bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [20:1] off_j;

    assign instr  = bus.i_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign imm_i  = instr[31:20];
    assign imm_s  = {instr[31:25], instr[11:7]};
    assign off_j  = {instr[31], instr[19:12], instr[20], instr[30:21]};

    logic is_jalr;
    logic is_jal;
    logic is_addi;
    logic is_add;
    logic is_lw;
    logic is_sw;

    // Full 7-bit opcode compares also reject words with [1:0] != 2'b11.
    assign is_jalr = (opcode == 7'b1100111) && (funct3 == 3'b000);
    assign is_jal  = (opcode == 7'b1101111);
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) &&
                     (funct7 == 7'b0000000);
    assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);

    logic rd_le1;
    logic rd_nz;
    logic rs1_nz;
    logic rs2_nz;
    logic rd_is_c;
    logic rs1_is_c;
    logic rs2_is_c;
    logic imm_i_fits6;
    logic off_j_fits12;

    assign rd_le1   = (rd[4:1] == 4'b0000);
    assign rd_nz    = (rd  != 5'd0);
    assign rs1_nz   = (rs1 != 5'd0);
    assign rs2_nz   = (rs2 != 5'd0);
    // x8..x15 are the registers reachable by the 3-bit RVC register fields.
    assign rd_is_c  = (rd[4:3]  == 2'b01);
    assign rs1_is_c = (rs1[4:3] == 2'b01);
    assign rs2_is_c = (rs2[4:3] == 2'b01);

    // A value fits a signed N-bit field when all bits above bit N-2 match
    // the sign bit of the narrower field.
    assign imm_i_fits6  = (&imm_i[11:5]) | ~(|imm_i[11:5]);
    assign off_j_fits12 = (&off_j[20:11]) | ~(|off_j[20:11]);

    // ------------------------------------------------------------------
    // Compression: first matching rule wins
    // ------------------------------------------------------------------
    logic        cand_ok;
    logic [15:0] cand_hw;
    logic        is_comp;

    always_comb begin
        cand_ok = 1'b0;
        cand_hw = 16'h0000;
        if (instr == 32'h0010_0073) begin
            // ebreak -> c.ebreak
            cand_ok = 1'b1;
            cand_hw = 16'h9002;
        end else if (is_jalr && rd_le1 && rs1_nz && (imm_i == 12'd0)) begin
            // c.jr (rd=0) / c.jalr (rd=1)
            cand_ok = 1'b1;
            cand_hw = {3'b100, rd[0], rs1, 5'b00000, 2'b10};
        end else if (is_jal && rd_le1 && off_j_fits12) begin
            // c.j (rd=0) / c.jal (rd=1)
            cand_ok = 1'b1;
            cand_hw = {(rd[0] ? 3'b001 : 3'b101), off_j[11], off_j[4],
                       off_j[9:8], off_j[10], off_j[6], off_j[7],
                       off_j[3:1], off_j[5], 2'b01};
        end else if (is_addi && rd_nz && !rs1_nz && imm_i_fits6) begin
            // c.li
            cand_ok = 1'b1;
            cand_hw = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (is_addi && rd_nz && (rs1 == rd) && (imm_i != 12'd0) &&
                     imm_i_fits6) begin
            // c.addi
            cand_ok = 1'b1;
            cand_hw = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (is_add && rd_nz && rs2_nz && !rs1_nz) begin
            // c.mv
            cand_ok = 1'b1;
            cand_hw = {4'b1000, rd, rs2, 2'b10};
        end else if (is_add && rd_nz && rs2_nz && (rs1 == rd)) begin
            // c.add
            cand_ok = 1'b1;
            cand_hw = {4'b1001, rd, rs2, 2'b10};
        end else if (is_lw && (rs1 == 5'd2) && rd_nz &&
                     (imm_i[11:8] == 4'd0) && (imm_i[1:0] == 2'd0)) begin
            // c.lwsp
            cand_ok = 1'b1;
            cand_hw = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        end else if (is_sw && (rs1 == 5'd2) &&
                     (imm_s[11:8] == 4'd0) && (imm_s[1:0] == 2'd0)) begin
            // c.swsp
            cand_ok = 1'b1;
            cand_hw = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        end else if (is_lw && rd_is_c && rs1_is_c &&
                     (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0)) begin
            // c.lw
            cand_ok = 1'b1;
            cand_hw = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6],
                       rd[2:0], 2'b00};
        end else if (is_sw && rs1_is_c && rs2_is_c &&
                     (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0)) begin
            // c.sw
            cand_ok = 1'b1;
            cand_hw = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6],
                       rs2[2:0], 2'b00};
        end
    end

    assign is_comp = COMPRESS && cand_ok;

    // ------------------------------------------------------------------
    // Packing state and output register
    // ------------------------------------------------------------------
    state_e      state_q;
    state_e      state_d;
    logic [15:0] resid_q;
    logic [15:0] resid_d;
    logic [31:0] word_q;
    logic [31:0] word_d;
    logic        valid_q;
    logic        valid_d;
    logic        comp_q;
    logic        comp_d;
    logic [15:0] ncomp_q;
    logic [15:0] ncomp_d;

    logic ready;
    logic acc_instr;
    logic acc_flush;

    assign ready     = !valid_q || bus.i_ready;
    assign acc_instr = bus.i_valid && ready;
    // An instruction beat takes precedence; flush only counts on its own.
    assign acc_flush = bus.i_flush && !bus.i_valid && ready;

    always_comb begin
        state_d = state_q;
        resid_d = resid_q;
        word_d  = word_q;
        valid_d = valid_q;
        comp_d  = comp_q;
        ncomp_d = ncomp_q;

        // Downstream takes the current word; a new word below may refill
        // the register in the same cycle without a bubble.
        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end

        if (acc_instr) begin
            comp_d = is_comp;
            if (is_comp && (ncomp_q != 16'hFFFF)) begin
                ncomp_d = ncomp_q + 16'd1;
            end
            if (state_q == ST_EMPTY) begin
                if (is_comp) begin
                    resid_d = cand_hw;
                    state_d = ST_HALF;
                end else begin
                    word_d  = instr;
                    valid_d = 1'b1;
                end
            end else begin
                if (is_comp) begin
                    word_d  = {cand_hw, resid_q};
                    valid_d = 1'b1;
                    state_d = ST_EMPTY;
                end else begin
                    // Misaligned 32-bit: low half completes this word, high
                    // half becomes the new residual.
                    word_d  = {instr[15:0], resid_q};
                    valid_d = 1'b1;
                    resid_d = instr[31:16];
                end
            end
        end else if (acc_flush && (state_q == ST_HALF)) begin
            word_d  = {PAD, resid_q};
            valid_d = 1'b1;
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            resid_q <= 16'h0000;
            word_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
            comp_q  <= 1'b0;
            ncomp_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            resid_q <= resid_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            comp_q  <= comp_d;
            ncomp_q <= ncomp_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_word    = word_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_comp    = comp_q;
    assign bus.o_ncomp   = ncomp_q;
    assign bus.dbg_state = (state_q == ST_HALF);

endmodule

// File: tb/tb_serv_comppack.sv
// -----------------------------------------------------------------------------
// tb_serv_comppack
//
// Directed bench for serv_comppack. A behavioural model turns each accepted
// instruction into halfword parcels in a queue and cuts complete words from
// that queue; a compare process checks the DUT against it every cycle.
// Literal expectations pin both DUT and model at key points.
// -----------------------------------------------------------------------------
module tb_serv_comppack;

    localparam logic [15:0] PAD = 16'h0001;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serv_comppack_if bus ();

    serv_comppack #(
        .COMPRESS (1'b1),
        .PAD      (PAD)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          chk_en   = 1'b0;
    logic [15:0] half_q[$];
    logic [31:0] exp_q[$];
    bit          exp_comp;
    int          exp_ncomp;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Reference compression straight from the RVC rules, using integer
    // ranges for immediates.
    function automatic logic [16:0] comp_model(input logic [31:0] w);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        int          imm_i;
        int          imm_s;
        int          imm_j;
        logic [11:0] o;
        op    = w[6:0];
        f3    = w[14:12];
        rd    = w[11:7];
        rs1   = w[19:15];
        rs2   = w[24:20];
        imm_i = int'($signed(w[31:20]));
        imm_s = int'($signed({w[31:25], w[11:7]}));
        imm_j = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        if (w == 32'h0010_0073) return {1'b1, 16'h9002};
        if (op == 7'h67 && f3 == 3'd0 && rd <= 5'd1 && rs1 != 5'd0 && imm_i == 0)
            return {1'b1, 3'b100, rd[0], rs1, 5'd0, 2'b10};
        if (op == 7'h6F && rd <= 5'd1 && imm_j >= -2048 && imm_j <= 2047) begin
            o = imm_j[11:0];
            return {1'b1, (rd == 5'd1) ? 3'b001 : 3'b101, o[11], o[4], o[9:8],
                    o[10], o[6], o[7], o[3:1], o[5], 2'b01};
        end
        if (op == 7'h13 && f3 == 3'd0 && rd != 5'd0 && imm_i >= -32 && imm_i <= 31) begin
            o = imm_i[11:0];
            if (rs1 == 5'd0) return {1'b1, 3'b010, o[5], rd, o[4:0], 2'b01};
            if (rs1 == rd && imm_i != 0) return {1'b1, 3'b000, o[5], rd, o[4:0], 2'b01};
        end
        if (op == 7'h33 && f3 == 3'd0 && w[31:25] == 7'd0 && rd != 5'd0 && rs2 != 5'd0) begin
            if (rs1 == 5'd0) return {1'b1, 4'b1000, rd, rs2, 2'b10};
            if (rs1 == rd)   return {1'b1, 4'b1001, rd, rs2, 2'b10};
        end
        if (op == 7'h03 && f3 == 3'd2 && imm_i >= 0 && imm_i % 4 == 0) begin
            o = imm_i[11:0];
            if (rs1 == 5'd2 && rd != 5'd0 && imm_i < 256)
                return {1'b1, 3'b010, o[5], rd, o[4:2], o[7:6], 2'b10};
            if (rd >= 5'd8 && rd <= 5'd15 && rs1 >= 5'd8 && rs1 <= 5'd15 && imm_i < 128)
                return {1'b1, 3'b010, o[5:3], rs1[2:0], o[2], o[6], rd[2:0], 2'b00};
        end
        if (op == 7'h23 && f3 == 3'd2 && imm_s >= 0 && imm_s % 4 == 0) begin
            o = imm_s[11:0];
            if (rs1 == 5'd2 && imm_s < 256)
                return {1'b1, 3'b110, o[5:2], o[7:6], rs2, 2'b10};
            if (rs1 >= 5'd8 && rs1 <= 5'd15 && rs2 >= 5'd8 && rs2 <= 5'd15 && imm_s < 128)
                return {1'b1, 3'b110, o[5:3], rs1[2:0], o[2], o[6], rs2[2:0], 2'b00};
        end
        return 17'd0;
    endfunction

    task automatic model_pack();
        logic [15:0] lo;
        logic [15:0] hi;
        while (half_q.size() >= 2) begin
            lo = half_q.pop_front();
            hi = half_q.pop_front();
            exp_q.push_back({hi, lo});
        end
    endtask

    task automatic model_instr(input logic [31:0] w);
        logic [16:0] r;
        r = comp_model(w);
        if (r[16]) begin
            half_q.push_back(r[15:0]);
            exp_comp = 1'b1;
            if (exp_ncomp < 65535) exp_ncomp++;
        end else begin
            half_q.push_back(w[15:0]);
            half_q.push_back(w[31:16]);
            exp_comp = 1'b0;
        end
        model_pack();
    endtask

    task automatic model_flush();
        if (half_q.size() == 1) half_q.push_back(PAD);
        model_pack();
    endtask

    task automatic model_clear();
        half_q.delete();
        exp_q.delete();
        exp_comp  = 1'b0;
        exp_ncomp = 0;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("o_valid", 32'(bus.o_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("o_word", bus.o_word, exp_q[0]);
            check("o_ready", 32'(bus.o_ready), 32'((exp_q.size() == 0) || bus.i_ready));
            check("o_comp", 32'(bus.o_comp), 32'(exp_comp));
            check("o_ncomp", 32'(bus.o_ncomp), 32'(exp_ncomp));
            check("state", 32'(bus.dbg_state), 32'(half_q.size()));
            if (exp_q.size() != 0 && bus.i_ready) void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks (enter/leave at posedge + 2) ----------------
    task automatic wait_ready(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!bus.o_ready) begin
            if (n >= 50) begin
                ok = 1'b0;
                break;
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        rst_n       = 1'b0;
        @(posedge clk);
        model_clear();
        chk_en = 1'b1;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic send_instr(input logic [31:0] w, input bit with_flush);
        bit ok;
        bus.i_instr = w;
        bus.i_valid = 1'b1;
        bus.i_flush = with_flush;
        wait_ready(ok);
        check("accept_instr", 32'(ok), 32'd1);
        if (ok) begin
            @(posedge clk);
            model_instr(w);
        end else begin
            @(posedge clk);
        end
        #2;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic send_flush();
        bit ok;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b1;
        wait_ready(ok);
        check("accept_flush", 32'(ok), 32'd1);
        @(posedge clk);
        if (ok) model_flush();
        #2;
        bus.i_flush = 1'b0;
    endtask

    task automatic pin_word(input string name, input logic [31:0] lit);
        check({name, "_dut"}, bus.o_word, lit);
        check({name, "_model"}, (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF, lit);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bus.i_instr = 32'h0;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #2;
        do_reset();
        check("rst_o_valid", 32'(bus.o_valid), 32'd0);
        check("rst_o_word", bus.o_word, 32'd0);
        check("rst_o_comp", 32'(bus.o_comp), 32'd0);
        check("rst_o_ncomp", 32'(bus.o_ncomp), 32'd0);

        // c.li x1,5 then flush
        send_instr(32'h0050_0093, 1'b0);
        check("li_no_out", 32'(bus.o_valid), 32'd0);
        check("li_comp", 32'(bus.o_comp), 32'd1);
        send_flush();
        check("li_flush_valid", 32'(bus.o_valid), 32'd1);
        pin_word("li_flush", 32'h0001_4095);
        check("li_ncomp", 32'(bus.o_ncomp), 32'd1);

        // c.add + c.j
        do_reset();
        send_instr(32'h00B5_0533, 1'b0);
        send_instr(32'h0080_006F, 1'b0);
        pin_word("add_j", 32'hA021_952E);
        check("add_j_state", 32'(bus.dbg_state), 32'd0);
        check("add_j_ncomp", 32'(bus.o_ncomp), 32'd2);

        // c.addi then misaligned lui, then flush
        send_instr(32'h0014_0413, 1'b0);
        send_instr(32'h1234_52B7, 1'b0);
        pin_word("addi_lui", 32'h52B7_0405);
        check("addi_lui_state", 32'(bus.dbg_state), 32'd1);
        send_flush();
        pin_word("lui_flush", 32'h0001_1234);
        check("lui_flush_ncomp", 32'(bus.o_ncomp), 32'd3);

        // addi out of 6-bit range passes through
        send_instr(32'h0200_8093, 1'b0);
        pin_word("addi_wide", 32'h0200_8093);
        check("addi_wide_comp", 32'(bus.o_comp), 32'd0);

        // ebreak + c.jr, c.jalr + c.mv, c.lwsp + c.swsp
        send_instr(32'h0010_0073, 1'b0);
        send_instr(32'h0000_8067, 1'b0);
        pin_word("ebreak_jr", 32'h8082_9002);
        send_instr(32'h0002_80E7, 1'b0);
        send_instr(32'h0060_02B3, 1'b0);
        pin_word("jalr_mv", 32'h829A_9282);
        send_instr(32'h00C1_2403, 1'b0);
        send_instr(32'h0091_2423, 1'b0);
        pin_word("lwsp_swsp", 32'hC426_4432);

        // Model-checked mix: c.lw, c.sw, negative c.addi, c.jal back,
        // far jal, nop, non-32-bit word, lw beyond lwsp range, and an
        // instruction presented together with flush.
        send_instr(32'h0045_2483, 1'b0);
        send_instr(32'h0095_2223, 1'b0);
        send_instr(32'hFFF1_8193, 1'b0);
        send_instr(32'hFFDF_F0EF, 1'b0);
        send_instr(32'h0000_10EF, 1'b0);
        send_instr(32'h0000_0013, 1'b0);
        send_instr(32'h0000_0001, 1'b0);
        send_instr(32'h1001_2403, 1'b0);
        send_instr(32'h0014_0413, 1'b1);
        send_flush();
        send_flush();

        // Backpressure: hold i_ready low with a word pending
        send_instr(32'h1234_52B7, 1'b0);
        bus.i_ready = 1'b0;
        bus.i_instr = 32'h0200_8093;
        bus.i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            check("stall_o_ready", 32'(bus.o_ready), 32'd0);
            check("stall_o_word", bus.o_word, 32'h1234_52B7);
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        model_instr(32'h0200_8093);
        #2;
        bus.i_valid = 1'b0;
        check("resume_valid", 32'(bus.o_valid), 32'd1);
        pin_word("resume", 32'h0200_8093);

        // Reset while a residual is pending
        send_instr(32'h0014_0413, 1'b0);
        check("half_before_rst", 32'(bus.dbg_state), 32'd1);
        do_reset();
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_ncomp", 32'(bus.o_ncomp), 32'd0);
        check("mid_rst_state", 32'(bus.dbg_state), 32'd0);
        send_flush();
        check("flush_empty_no_out", 32'(bus.o_valid), 32'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
